adc_spi_responder: RTL
======================

Name: adc_spi_responder

Overview:
Synthesizable SPI responder that emulates the MCP3002-style 2-channel, 10-bit ADC on the far end of the existing ADC SPI link. It is driven by the spi2adc master (chip select, serial clock, configuration bits) and returns 10-bit samples taken from two parallel channel inputs. It is used for loopback testing on the MAX10 board and as the ADC model in system benches, alongside the DAC and sampling-tick chain.

Parameters:
DATA_W, 10, sample width in bits.
SYNC_STAGES, 2, synchroniser depth on adc_cs, adc_sck and sdi (minimum 2).

Ports:
sysclk  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous active-low reset.
adc_cs  input  1  chip select from the master, active low.
adc_sck  input  1  serial clock from the master, ≤ 1 MHz, idle high or low.
sdi  input  1  configuration data from the master (ADC DIN).
sdo  output  1  serial data to the master (ADC DOUT).
sdo_oe  output  1  sdo drive enable; 0 means the pad is tri-stated.
ch0_data  input  DATA_W  parallel sample for channel 0.
ch1_data  input  DATA_W  parallel sample for channel 1.
sample_strobe  output  1  one-sysclk pulse when the sample is latched.
frame_done  output  1  one-sysclk pulse when the last data bit has been shifted out.
last_cfg  output  3  {sgl_diff, odd_sign, msbf} from the most recent complete configuration.

Behaviour:
- Reset: FSM=IDLE; sdo=0; sdo_oe=0; sample_strobe=0; frame_done=0; last_cfg=3'b110; shift register=0; synchronisers preset to adc_cs=1, adc_sck=0, sdi=0.
- All inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised adc_sck. Action takes place one cycle after detection, so total latency is SYNC_STAGES+1 sysclk cycles after the pin edge. This is about 60 ns at 50 MHz, well inside half a 1 MHz SCK period.
- Bit convention: sdi is sampled on the SCK rising edge. sdo changes on the SCK falling edge.
- adc_cs high (synchronised) forces IDLE from any state in the next cycle, with sdo_oe=0 and sdo=0. A partial frame is discarded and last_cfg is unchanged.
- States:
  - IDLE: on adc_cs falling, go to WAIT_START and set sdo_oe=1, sdo=0.
  - WAIT_START: on a rising edge with sdi=1, go to CFG with bit count 0. Rising edges with sdi=0 are ignored (leading zeros are allowed).
  - CFG: capture sgl_diff, odd_sign, msbf on the next 3 rising edges. On the 3rd edge:
    - Latch the sample.
    - Pulse sample_strobe.
    - Update last_cfg.
    - Go to NULLB.
  - NULLB: on the next falling edge, drive sdo=0 (null bit), then go to DATA with index DATA_W-1.
  - DATA: on each falling edge, drive sample[index] MSB-first. After bit 0 has been driven, pulse frame_done and go to one of:
    - LSB_TAIL if msbf=0;
    - ZEROS if msbf=1.
  - LSB_TAIL: on falling edges, drive sample[1] through sample[DATA_W-1], then go to ZEROS. frame_done is not re-pulsed.
  - ZEROS: drive sdo=0 on every falling edge until adc_cs rises.
- Sample selection, latched once per frame:
  - sgl_diff=1, odd_sign=0: ch0_data.
  - sgl_diff=1, odd_sign=1: ch1_data.
  - sgl_diff=0, odd_sign=0: ch0−ch1, saturated at 0 (unsigned DATA_W).
  - sgl_diff=0, odd_sign=1: ch1−ch0, saturated at 0.
- The subtraction is done at DATA_W+1 bits. A negative result (borrow) clamps to 0.
- Changes on ch0_data/ch1_data after the latch do not affect the frame in progress.
- Simultaneous adc_cs rise and SCK edge in the same sysclk cycle: adc_cs takes priority and the SCK edge is ignored.
- Extra SCK edges beyond the frame stay in ZEROS. Edges are never counted while adc_cs is high.
- The SCK idle level is not checked; only edge direction matters.

Decomposition:
- Shared package adc_spi_pkg:
  - FSM state enum: IDLE, WAIT_START, CFG, NULLB, DATA, LSB_TAIL, ZEROS.
  - CFG_BITS=3.
  - Reset default for last_cfg.
  - Mode encodings.
- One natural sub-module, spi_pin_sync: parameterised N-stage synchroniser with rise and fall pulse outputs, instantiated for adc_sck and as a plain synchroniser for adc_cs and sdi.

Test Plan:
- Drive adc_cs low, sdi bits 1,1,0,1 (single-ended ch0, MSB first) with ch0=10'h2A5, 1 MHz SCK → sdo bits after cfg: 0, then 1,0,1,0,1,0,0,1,0,1; frame_done after the 10th bit; last_cfg=3'b101.
- Same frame with cfg 1,1,1 and ch1=10'h3FF, ch0=0 → data 10'h3FF; sample_strobe pulses exactly once; a ch1 change after the strobe is not reflected.
- Differential with ch0=10'd100, ch1=10'd300: odd_sign=0 → 0; odd_sign=1 → 10'd200.
- msbf=0, ch0=10'h201 → MSB-first 10'h201, then 9 LSB-first bits 0,0,0,0,0,0,0,0,1, then zeros.
- Raise adc_cs after 4 data bits → sdo_oe=0 within SYNC_STAGES+1 cycles; no frame_done. The next full frame is correct.
- Assert rst_n low mid-frame → all outputs return to reset values immediately, and the next frame after release is correct.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared constants for the MCP3002-style ADC responder: FSM state codes,
// configuration field layout, reset defaults and channel mode encodings.
package adc_spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_START = 3'd1;
  localparam state_t ST_CFG        = 3'd2;
  localparam state_t ST_NULLB      = 3'd3;
  localparam state_t ST_DATA       = 3'd4;
  localparam state_t ST_LSB_TAIL   = 3'd5;
  localparam state_t ST_ZEROS      = 3'd6;

  // Configuration word is {sgl_diff, odd_sign, msbf}.
  localparam int CFG_BITS = 3;
  localparam logic [CFG_BITS-1:0] LAST_CFG_RST = 3'b110;

  // Channel mode = {sgl_diff, odd_sign}.
  localparam logic [1:0] MODE_DIFF_01 = 2'b00;
  localparam logic [1:0] MODE_DIFF_10 = 2'b01;
  localparam logic [1:0] MODE_SGL_CH0 = 2'b10;
  localparam logic [1:0] MODE_SGL_CH1 = 2'b11;

endpackage

// File: rtl/adc_spi_responder_sync.sv
// N-stage synchroniser with a programmable reset level and single-cycle
// rise/fall pulses derived from the synchronised value.
module spi_pin_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [N-1:0] stages;
  logic         prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {N{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      stages <= {stages[N-2:0], din};
      prev   <= stages[N-1];
    end
  end

  // Edge pulses are combinational so the consumer acts on the next clock.
  assign sync = stages[N-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 2-channel, 10-bit MCP3002-style ADC: takes the
// start/config bits on SCK rising edges and returns the sample on falling edges.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                adc_cs,
  input  logic                adc_sck,
  input  logic                sdi,
  output logic                sdo,
  output logic                sdo_oe,
  input  logic [DATA_W-1:0]   ch0_data,
  input  logic [DATA_W-1:0]   ch1_data,
  output logic                sample_strobe,
  output logic                frame_done,
  output logic [CFG_BITS-1:0] last_cfg,
  output state_t              dbg_state
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(sysclk), .rst_n(rst_n), .din(adc_cs),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(sysclk), .rst_n(rst_n), .din(adc_sck),
    .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(sysclk), .rst_n(rst_n), .din(sdi),
    .sync(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );

  logic unused_sync_bits;
  assign unused_sync_bits = &{1'b0, cs_rise, sck_s, sdi_rise, sdi_fall};

  state_t                state;
  logic [1:0]            cfg_cnt;
  logic [CFG_BITS-2:0]   cfg_shift;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     sample;
  logic                  msbf_r;

  logic [CFG_BITS-1:0]   cfg_next;
  logic [DATA_W:0]       diff_01;
  logic [DATA_W:0]       diff_10;
  logic [DATA_W-1:0]     sel_sample;

  // The third config bit arrives on the same edge that latches the sample.
  assign cfg_next = {cfg_shift, sdi_s};
  assign diff_01  = {1'b0, ch0_data} - {1'b0, ch1_data};
  assign diff_10  = {1'b0, ch1_data} - {1'b0, ch0_data};

  // A borrow out of the extended subtraction saturates the result at zero.
  always_comb begin
    sel_sample = '0;
    unique case (cfg_next[2:1])
      MODE_SGL_CH0: sel_sample = ch0_data;
      MODE_SGL_CH1: sel_sample = ch1_data;
      MODE_DIFF_01: sel_sample = diff_01[DATA_W] ? '0 : diff_01[DATA_W-1:0];
      MODE_DIFF_10: sel_sample = diff_10[DATA_W] ? '0 : diff_10[DATA_W-1:0];
      default:      sel_sample = '0;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sdo           <= 1'b0;
      sdo_oe        <= 1'b0;
      sample_strobe <= 1'b0;
      frame_done    <= 1'b0;
      last_cfg      <= LAST_CFG_RST;
      sample        <= '0;
      cfg_shift     <= '0;
      cfg_cnt       <= '0;
      idx           <= '0;
      msbf_r        <= 1'b1;
    end else begin
      sample_strobe <= 1'b0;
      frame_done    <= 1'b0;
      // Deselect wins over any SCK edge seen in the same cycle.
      if (cs_s) begin
        state  <= ST_IDLE;
        sdo_oe <= 1'b0;
        sdo    <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state  <= ST_WAIT_START;
              sdo_oe <= 1'b1;
              sdo    <= 1'b0;
            end
          end
          ST_WAIT_START: begin
            if (sck_rise && sdi_s) begin
              state   <= ST_CFG;
              cfg_cnt <= '0;
            end
          end
          ST_CFG: begin
            if (sck_rise) begin
              if (cfg_cnt == 2'(CFG_BITS - 1)) begin
                sample        <= sel_sample;
                sample_strobe <= 1'b1;
                last_cfg      <= cfg_next;
                msbf_r        <= sdi_s;
                state         <= ST_NULLB;
              end else begin
                cfg_shift <= cfg_next[CFG_BITS-2:0];
                cfg_cnt   <= cfg_cnt + 1'b1;
              end
            end
          end
          ST_NULLB: begin
            if (sck_fall) begin
              sdo   <= 1'b0;
              idx   <= IDX_MSB;
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sck_fall) begin
              sdo <= sample[idx];
              if (idx == '0) begin
                frame_done <= 1'b1;
                idx        <= IDX_W'(1);
                state      <= msbf_r ? ST_ZEROS : ST_LSB_TAIL;
              end else begin
                idx <= idx - 1'b1;
              end
            end
          end
          ST_LSB_TAIL: begin
            if (sck_fall) begin
              sdo <= sample[idx];
              if (idx == IDX_MSB) state <= ST_ZEROS;
              else                idx   <= idx + 1'b1;
            end
          end
          ST_ZEROS: begin
            if (sck_fall) sdo <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule
